// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_pkg
// Brief    : Shared types for the arbitrating-mux family (arbitration mode).
// Revision : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

  // Arbitration policy selector shared by all arbiters of this family
  typedef enum logic {
    ARB_RR    = 1'b0,   // cyclic search starting at the rotating pointer
    ARB_FIXED = 1'b1    // lowest requesting index always wins
  } arb_mode_e;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational cyclic priority search. Returns the first set
//            request at or after ptr (wrapping), or the lowest set request
//            when fixed is high. grant is one-hot or zero.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            fixed,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] gidx,
  output logic            any
);

  // Search origin: pointer in round-robin mode, index 0 in fixed mode
  int w_start;
  assign w_start = fixed ? 0 : int'(ptr);

  // Two passes give the cyclic order: first [start..N-1], then [0..start-1]
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && (i >= w_start) && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        gidx     = SELW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && (i < w_start) && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        gidx     = SELW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux
// Brief    : N-channel WIDTH-bit arbitrating mux with valid/ready handshakes
//            and a single registered output slot. Round-robin or
//            fixed-priority selection of one winner per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_mux
  import arb_mux_pkg::*;
#(
  parameter  int        WIDTH = 4,
  parameter  int        N     = 4,
  parameter  arb_mode_e MODE  = ARB_RR,
  localparam int        SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  localparam logic C_FIXED = (MODE == ARB_FIXED);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;
  logic [SELW-1:0]  r_ptr;

  logic             w_free;
  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_gidx;
  logic             w_any;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  // Output slot can take a word when empty or being drained this cycle
  assign w_free = !r_out_valid || out_ready;

  rr_picker #(.N(N)) u_picker (
    .req   (in_valid),
    .ptr   (r_ptr),
    .fixed (C_FIXED),
    .grant (w_grant),
    .gidx  (w_gidx),
    .any   (w_any)
  );

  // Grant depends only on valids and pointer, never on data
  assign in_ready = (reset_n && w_free) ? w_grant : '0;
  assign w_xfer   = reset_n && w_free && w_any;

  // One-hot select of the winning channel's word
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output slot: load on transfer, empty when free with no request, hold otherwise
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_free) begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_sel   <= w_gidx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Rotating pointer moves just past the winner; stays 0 in fixed mode
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_xfer && !C_FIXED) begin
      r_ptr <= (w_gidx == SELW'(N - 1)) ? '0 : w_gidx + SELW'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_mux
// Brief    : Self-checking bench: round-robin N=4, fixed-priority N=4 and
//            round-robin N=3 instances against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux;
  import arb_mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  valid;
  logic [15:0] data;
  logic        out_ready;

  logic [3:0] rdy4, rdyf;
  logic [2:0] rdy3;
  logic       ov4, ovf, ov3;
  logic [3:0] od4, odf, od3;
  logic [1:0] os4, osf, os3;

  rr_arb_mux #(.WIDTH(4), .N(4), .MODE(ARB_RR)) u_rr4 (
    .clk(clk), .reset_n(rst_n), .in_valid(valid), .in_ready(rdy4), .in_data(data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_sel(os4));

  rr_arb_mux #(.WIDTH(4), .N(4), .MODE(ARB_FIXED)) u_fx4 (
    .clk(clk), .reset_n(rst_n), .in_valid(valid), .in_ready(rdyf), .in_data(data),
    .out_valid(ovf), .out_ready(out_ready), .out_data(odf), .out_sel(osf));

  rr_arb_mux #(.WIDTH(4), .N(3), .MODE(ARB_RR)) u_rr3 (
    .clk(clk), .reset_n(rst_n), .in_valid(valid[2:0]), .in_ready(rdy3), .in_data(data[11:0]),
    .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .out_sel(os3));

  int tests = 0;
  int fails = 0;

  // Model state per instance: 0 = rr4, 1 = fixed4, 2 = rr3
  int m_ov[3]  = '{0, 0, 0};
  int m_od[3]  = '{0, 0, 0};
  int m_os[3]  = '{0, 0, 0};
  int m_ptr[3] = '{0, 0, 0};
  int c_n[3]   = '{4, 4, 3};
  int c_fx[3]  = '{0, 1, 0};

  // Winner: first valid channel in cyclic order from start, -1 if none
  function automatic int pick(int n, logic [3:0] v, int start);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (start + k) % n;
      if (v[i[1:0]]) return i;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check handshake before the edge, advance model, check outputs after
  task automatic cycle();
    int w[3];
    int fr[3];
    int e[3];
    #1;
    for (int j = 0; j < 3; j++) begin
      fr[j] = (m_ov[j] == 0 || out_ready) ? 1 : 0;
      w[j]  = pick(c_n[j], valid, (c_fx[j] != 0) ? 0 : m_ptr[j]);
      e[j]  = (rst_n === 1'b1 && fr[j] != 0 && w[j] >= 0) ? (1 << w[j]) : 0;
    end
    check("in_ready_rr4", 32'(rdy4), e[0]);
    check("in_ready_fx4", 32'(rdyf), e[1]);
    check("in_ready_rr3", 32'(rdy3), e[2]);
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      if (rst_n !== 1'b1) begin
        m_ov[j] = 0; m_od[j] = 0; m_os[j] = 0; m_ptr[j] = 0;
      end else if (fr[j] != 0) begin
        if (w[j] >= 0) begin
          m_od[j] = int'((data >> (4 * w[j])) & 16'hF);
          m_os[j] = w[j];
          m_ov[j] = 1;
          if (c_fx[j] == 0) m_ptr[j] = (w[j] + 1) % c_n[j];
        end else begin
          m_ov[j] = 0;
        end
      end
    end
    #1;
    check("out_valid_rr4", 32'(ov4), m_ov[0]);
    check("out_data_rr4",  32'(od4), m_od[0]);
    check("out_sel_rr4",   32'(os4), m_os[0]);
    check("out_valid_fx4", 32'(ovf), m_ov[1]);
    check("out_data_fx4",  32'(odf), m_od[1]);
    check("out_sel_fx4",   32'(osf), m_os[1]);
    check("out_valid_rr3", 32'(ov3), m_ov[2]);
    check("out_data_rr3",  32'(od3), m_od[2]);
    check("out_sel_rr3",   32'(os3), m_os[2]);
  endtask

  int rot_s[5] = '{0, 1, 2, 3, 0};
  int rot_d[5] = '{0, 5, 10, 15, 0};
  int rot3[4]  = '{0, 1, 2, 0};

  initial begin
    // Reset held two cycles with every channel requesting
    rst_n = 1'b0; valid = 4'hF; data = 16'hFA50; out_ready = 1'b1;
    cycle();
    cycle();
    check("t1_out_valid", 32'(ov4), 0);
    check("t1_in_ready",  32'(rdy4), 0);
    check("t1_out_data",  32'(od4), 0);

    // Single requesting channel
    rst_n = 1'b1; valid = 4'b0100;
    cycle();
    check("t2_out_data", 32'(od4), 32'hA);
    check("t2_out_sel",  32'(os4), 2);

    // Round-robin rotation from a fresh pointer
    rst_n = 1'b0; valid = 4'b0000;
    cycle();
    rst_n = 1'b1; valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t3_rot_sel",  32'(os4), rot_s[k]);
      check("t3_rot_data", 32'(od4), rot_d[k]);
      check("t3_fixed_sel", 32'(osf), 0);
    end

    // Backpressure: word 5 held while consumer stalls
    valid = 4'b0010;
    cycle();
    check("t4_first_data", 32'(od4), 5);
    out_ready = 1'b0; valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t4_hold_data",  32'(od4), 5);
      check("t4_hold_ready", 32'(rdy4), 0);
      check("t4_hold_valid", 32'(ov4), 1);
    end
    out_ready = 1'b1;
    cycle();
    check("t4_release_data", 32'(od4), 32'hA);
    check("t4_release_sel",  32'(os4), 2);

    // Fixed priority: lowest valid index always wins
    valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t5_fixed_sel",  32'(osf), 1);
      check("t5_fixed_data", 32'(odf), 5);
    end

    // N=3 wrap, then reset while a word is held
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; valid = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t6_wrap_sel", 32'(os3), rot3[k]);
    end
    check("t6_held_valid", 32'(ov3), 1);
    rst_n = 1'b0;
    cycle();
    check("t6_reset_valid", 32'(ov3), 0);
    rst_n = 1'b1;
    cycle();
    check("t6_after_sel",   32'(os3), 0);
    check("t6_after_valid", 32'(ov3), 1);

    // Randomised traffic with occasional resets and stalls
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      valid     = 4'($urandom);
      data      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
